// File: rtl/muldiv_unit.sv
// Multiply/divide/accumulate unit for the E stage: long ops compute into a shadow
// pair and commit to HI/LO after a fixed, parametrised latency while busy is held.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_by_zero
);
    localparam int DW         = 2 * WIDTH;
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic signed [WIDTH-1:0] S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_NEG1 = '1;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [DW-1:0] mul_s(input logic signed [WIDTH-1:0] a,
                                            input logic signed [WIDTH-1:0] b);
        logic signed [DW-1:0] ax;
        logic signed [DW-1:0] bx;
        ax = {{WIDTH{a[WIDTH-1]}}, a};
        bx = {{WIDTH{b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [DW-1:0] mul_u(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        logic [DW-1:0] ax;
        logic [DW-1:0] bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; zero divisor yields zeros (masked at commit).
    function automatic logic [DW-1:0] div_s(input logic signed [WIDTH-1:0] a,
                                            input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        if (b == '0) begin
            q = '0;
            r = '0;
        end else if (a == S_MIN && b == S_NEG1) begin
            q = S_MIN;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [DW-1:0] div_u(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        if (b == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sl;
    logic             dz_pend;

    logic [DW-1:0] acc;
    logic [DW-1:0] prod_s;
    logic [DW-1:0] prod_u;
    logic [DW-1:0] long_res;
    logic          op_known;
    logic          is_div;
    logic          accept;

    always_comb begin
        acc      = {hi, lo};
        prod_s   = mul_s(src_a, src_b);
        prod_u   = mul_u(src_a, src_b);
        long_res = acc;
        op_known = 1'b1;
        is_div   = 1'b0;
        case (op)
            OP_MULT:  long_res = prod_s;
            OP_MULTU: long_res = prod_u;
            OP_MADD:  long_res = acc + prod_s;
            OP_MADDU: long_res = acc + prod_u;
            OP_MSUB:  long_res = acc - prod_s;
            OP_MSUBU: long_res = acc - prod_u;
            OP_DIV: begin
                long_res = div_s(src_a, src_b);
                is_div   = 1'b1;
            end
            OP_DIVU: begin
                long_res = div_u(src_a, src_b);
                is_div   = 1'b1;
            end
            OP_MTHI, OP_MTLO: long_res = acc;
            default: op_known = 1'b0;
        endcase
        accept = op_valid && !flush && !busy && op_known;
    end

    // Accumulate ops read {hi,lo} at the accept edge; an in-flight op ignores flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            sh          <= '0;
            sl          <= '0;
            dz_pend     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (count == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (dz_pend) begin
                            div_by_zero <= 1'b1;
                        end else begin
                            hi          <= sh;
                            lo          <= sl;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end else begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            count    <= is_div ? DIV_LOAD : MULT_LOAD;
                            {sh, sl} <= long_res;
                            dz_pend  <= is_div && (src_b == '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a transaction-level model tracks HI/LO/busy/flag
// every cycle, and hand-computed literals pin the expected results.
module tb_muldiv_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_by_zero;

    logic        op_valid16;
    logic [3:0]  op16;
    logic [15:0] src_a16;
    logic [15:0] src_b16;
    logic        flush16;
    logic [15:0] hi16;
    logic [15:0] lo16;
    logic        busy16;
    logic        dz16;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;
    logic [63:0] m_res;
    logic        m_pdz;
    int          m_left;

    muldiv_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .div_by_zero(div_by_zero)
    );

    muldiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(DC)) dut16 (
        .clk(clk), .reset(reset), .op_valid(op_valid16), .op(op16),
        .src_a(src_a16), .src_b(src_b16), .flush(flush16),
        .hi(hi16), .lo(lo16), .busy(busy16), .div_by_zero(dz16)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one rising edge, from the inputs held at that edge.
    task automatic model_step();
        logic [63:0] acc;
        logic [63:0] ua;
        logic [63:0] ub;
        longint sa;
        longint sb;
        longint q;
        longint r;
        acc = {m_hi, m_lo};
        ua  = {32'b0, src_a};
        ub  = {32'b0, src_b};
        sa  = longint'($signed(src_a));
        sb  = longint'($signed(src_b));
        if (reset) begin
            m_hi = '0; m_lo = '0; m_dz = 1'b0; m_left = 0; m_pdz = 1'b0; m_res = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_pdz) m_dz = 1'b1;
                else begin
                    {m_hi, m_lo} = m_res;
                    m_dz = 1'b0;
                end
            end
        end else if (op_valid && !flush && op >= 4'd1 && op <= 4'd10) begin
            m_pdz = 1'b0;
            m_left = MC;
            case (op)
                4'd1: m_res = sa * sb;
                4'd2: m_res = ua * ub;
                4'd5: m_res = acc + 64'(sa * sb);
                4'd6: m_res = acc + ua * ub;
                4'd7: m_res = acc - 64'(sa * sb);
                4'd8: m_res = acc - ua * ub;
                4'd3: begin
                    m_left = DC;
                    if (src_b == 0) m_pdz = 1'b1;
                    else begin
                        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                        if ((sa < 0) != (sb < 0)) q = -q;
                        r = sa - q * sb;
                        m_res = {32'(r), 32'(q)};
                    end
                end
                4'd4: begin
                    m_left = DC;
                    if (src_b == 0) m_pdz = 1'b1;
                    else m_res = {src_a % src_b, src_a / src_b};
                end
                4'd9: begin m_hi = src_a; m_left = 0; end
                default: begin m_lo = src_a; m_left = 0; end
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if ({hi, lo, busy, div_by_zero} !== {m_hi, m_lo, (m_left > 0), m_dz}) begin
                miscompares++;
                $display("FAIL model t=%0t: got hi=%h lo=%h busy=%b dz=%b expected hi=%h lo=%h busy=%b dz=%b",
                         $time, hi, lo, busy, div_by_zero, m_hi, m_lo, (m_left > 0), m_dz);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
        tick();
        op_valid = 1'b0; op = 4'd0; flush = 1'b0;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0; flush = 1'b0;
        op_valid16 = 1'b0; op16 = 4'd0; src_a16 = '0; src_b16 = '0; flush16 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_en = 1'b1;
        chk("reset state", {hi, lo, 31'b0, busy, 31'b0, div_by_zero}, '0);

        // mult -3 * 5
        issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_busy(n);
        chk("mult busy len", 64'(n), 64'd5);
        chk("mult hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        // div -7 / 2
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_busy(n);
        chk("div busy len", 64'(n), 64'd10);
        chk("div hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        chk("div dz", 64'(div_by_zero), 64'd0);

        // mtlo, divu by zero, mthi keeps flag, multu clears it
        issue(4'd10, 32'h1234, 32'd0, 1'b0);
        chk("mtlo busy", 64'(busy), 64'd0);
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        run_busy(n);
        chk("divu0 busy len", 64'(n), 64'd10);
        chk("divu0 hilo", {hi, lo}, 64'hFFFFFFFF_00001234);
        chk("divu0 dz", 64'(div_by_zero), 64'd1);
        issue(4'd9, 32'h55, 32'd0, 1'b0);
        chk("mthi keeps dz", {hi, 31'b0, div_by_zero}, {32'h55, 32'd1});
        issue(4'd2, 32'd2, 32'd3, 1'b0);
        run_busy(n);
        chk("multu hilo", {hi, lo}, 64'h0_00000006);
        chk("multu dz", 64'(div_by_zero), 64'd0);

        // maddu then msub
        issue(4'd9, 32'd0, 32'd0, 1'b0);
        issue(4'd10, 32'd10, 32'd0, 1'b0);
        issue(4'd6, 32'd3, 32'd4, 1'b0);
        run_busy(n);
        chk("maddu hilo", {hi, lo}, 64'd22);
        issue(4'd7, 32'd1, 32'd30, 1'b0);
        run_busy(n);
        chk("msub hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF8);

        // flushed op and unknown ops are dropped
        issue(4'd1, 32'd7, 32'd7, 1'b1);
        chk("flush busy", 64'(busy), 64'd0);
        issue(4'd11, 32'd7, 32'd7, 1'b0);
        issue(4'd0, 32'd7, 32'd7, 1'b0);
        chk("noop hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF8);

        // mthi and flush while busy: ignored, op still commits
        issue(4'd1, 32'd2, 32'd2, 1'b0);
        issue(4'd9, 32'hDEAD, 32'd0, 1'b1);
        run_busy(n);
        chk("busy mthi len", 64'(n), 64'd4);
        chk("busy mthi hilo", {hi, lo}, 64'd4);

        // signed madd, MIN/-1, div with negative divisor
        issue(4'd5, 32'hFFFFFFFE, 32'd3, 1'b0);
        run_busy(n);
        chk("madd hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_busy(n);
        chk("div min/-1", {hi, lo}, 64'h00000000_80000000);
        issue(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0);
        run_busy(n);
        chk("div 7/-2", {hi, lo}, 64'h00000001_FFFFFFFD);
        issue(4'd4, 32'hFFFFFFFF, 32'd16, 1'b0);
        run_busy(n);
        chk("divu big", {hi, lo}, 64'h0000000F_0FFFFFFF);

        // reset on busy cycle 3 aborts the op
        issue(4'd1, 32'd3, 32'd3, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hilo", {hi, lo}, 64'd0);
        repeat (8) tick();
        chk("no late commit", {hi, lo, 31'b0, busy}, 96'd0);

        // 16-bit instance, single-cycle multiply
        op_valid16 = 1'b1; op16 = 4'd1; src_a16 = 16'hFFFD; src_b16 = 16'd5;
        tick();
        op_valid16 = 1'b0; op16 = 4'd0;
        chk("w16 busy", 64'(busy16), 64'd1);
        tick();
        chk("w16 busy fall", 64'(busy16), 64'd0);
        chk("w16 hilo", 64'({hi16, lo16}), 64'hFFFF_FFF1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
